risc16_mem_target: RTL

//  Memory-side responder for the risc16b core's instruction and data ports.

---
 rtl/risc16_mem_pkg.sv | 30 +++
 rtl/risc16_mem_target_if.sv | 47 ++++
 rtl/risc16_bram.sv | 38 +++
 rtl/risc16_mem_target.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/risc16_mem_pkg.sv
// risc16_mem_pkg
//   Shared types and constants for the risc16 memory target slice.
//   state_t      : loader/run-control FSM states
//   WE_*         : d_we byte-lane encodings (bit 0 selects bits[15:8], bit 1 selects bits[7:0])
//   merge_lanes  : applies a d_we-style byte-lane write to an existing word
`timescale 1ns/1ps
package risc16_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam logic [1:0] WE_NONE = 2'b00;
   localparam logic [1:0] WE_WORD = 2'b11;
   localparam logic [1:0] WE_HI   = 2'b01;
   localparam logic [1:0] WE_LO   = 2'b10;

   function automatic logic [15:0] merge_lanes(input logic [15:0] old_w,
                                               input logic [15:0] new_w,
                                               input logic [1:0]  we);
      logic [15:0] res;
      res = old_w;
      if ((we & WE_HI) != WE_NONE) res[15:8] = new_w[15:8];
      if ((we & WE_LO) != WE_NONE) res[7:0]  = new_w[7:0];
      return res;
   endfunction

endpackage

// File: rtl/risc16_mem_target_if.sv
// risc16_mem_target_if
//   Bundles the core instruction/data ports, the host loader stream and the
//   run-control/status outputs of risc16_mem_target.
//   slave  : the memory target side (drives read data, ld_ready, cpu_rst, status, mmio)
//   master : the core + host side (drives addresses, enables, store data, load stream)
//   Parameter AW must match the AW of the attached risc16_mem_target.
`timescale 1ns/1ps
interface risc16_mem_target_if #(parameter int AW = 10);

   // core instruction port
   logic [15:0] i_addr;
   logic        i_oe;
   logic [15:0] i_rdata;
   // core data port
   logic [15:0] d_addr;
   logic        d_oe;
   logic [1:0]  d_we;
   logic [15:0] d_wdata;
   logic [15:0] d_rdata;
   // host loader stream
   logic        ld_start;
   logic        ld_valid;
   logic [15:0] ld_data;
   logic        ld_last;
   logic        ld_ready;
   // run control and status
   logic        cpu_rst;
   logic [AW:0] ld_count;
   logic        ld_ovf;
   logic [15:0] mmio_out;
   logic        mmio_stb;

   modport slave (
      input  i_addr, i_oe, d_addr, d_oe, d_we, d_wdata,
             ld_start, ld_valid, ld_data, ld_last,
      output i_rdata, d_rdata, ld_ready, cpu_rst, ld_count, ld_ovf,
             mmio_out, mmio_stb
   );

   modport master (
      output i_addr, i_oe, d_addr, d_oe, d_we, d_wdata,
             ld_start, ld_valid, ld_data, ld_last,
      input  i_rdata, d_rdata, ld_ready, cpu_rst, ld_count, ld_ovf,
             mmio_out, mmio_stb
   );

endinterface

// File: rtl/risc16_bram.sv
// risc16_bram
//   2**AW x 16-bit RAM with two asynchronous read ports and one synchronous
//   byte-lane write port. Contents are not reset.
//   clk              : write clock
//   ra_addr/ra_data  : read port A (word address, combinational data)
//   rb_addr/rb_data  : read port B (word address, combinational data)
//   w_en             : lane enables, d_we encoding (bit 0 -> bits[15:8], bit 1 -> bits[7:0])
//   w_addr/w_data    : write word address and data
//   A read of the word being written in the same cycle returns the old contents.
`timescale 1ns/1ps
module risc16_bram
   import risc16_mem_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic [AW-1:0] ra_addr,
   output logic [15:0]   ra_data,
   input  logic [AW-1:0] rb_addr,
   output logic [15:0]   rb_data,
   input  logic [1:0]    w_en,
   input  logic [AW-1:0] w_addr,
   input  logic [15:0]   w_data
);

   localparam int DEPTH = 2**AW;

   logic [15:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if ((w_en & WE_HI) != WE_NONE) mem[w_addr][15:8] <= w_data[15:8];
      if ((w_en & WE_LO) != WE_NONE) mem[w_addr][7:0]  <= w_data[7:0];
   end

   assign ra_data = mem[ra_addr];
   assign rb_data = mem[rb_addr];

endmodule

// File: rtl/risc16_mem_target.sv
// risc16_mem_target
//   Memory-side responder for the risc16b core. Serves combinational reads on
//   the instruction and data ports and byte-lane stores on the data port. A host
//   loader stream (valid/ready) holds the core in reset, fills RAM from word 0
//   and then releases the core.
//
//   Ports
//     clk  : clock
//     rst  : synchronous, active-high reset (FSM -> IDLE, cpu_rst = 1, RAM kept)
//     bus  : risc16_mem_target_if.slave
//            i_addr/i_oe/i_rdata         instruction read port
//            d_addr/d_oe/d_we/d_wdata/d_rdata  data read/store port
//            ld_start/ld_valid/ld_data/ld_last/ld_ready  host load stream
//            cpu_rst, ld_count, ld_ovf   run control and load status
//            mmio_out, mmio_stb          output register (RISC16_MMIO_EN only)
//
//   Configuration
//     RISC16_MMIO_EN : when defined, stores to MMIO_ADDR update mmio_out (and
//                      pulse mmio_stb) instead of RAM, and data reads of
//                      MMIO_ADDR return mmio_out. When undefined, mmio_out and
//                      mmio_stb are 0 and MMIO_ADDR aliases into RAM.
//
//   Word index is addr[AW:1]; higher address bits alias and addr[0] is ignored.
`timescale 1ns/1ps
module risc16_mem_target
   import risc16_mem_pkg::*;
#(
   parameter int          AW        = 10,
   parameter logic [15:0] MMIO_ADDR = 16'hFFFE
) (
   input  logic               clk,
   input  logic               rst,
   risc16_mem_target_if.slave bus
);

   localparam logic [AW:0] LAST_IDX = {1'b0, {AW{1'b1}}};

   state_t        state;
   state_t        next_state;
   logic          cpu_rst;
   logic [AW:0]   ld_count;
   logic          ld_ovf;
   logic          ld_ready;
   logic          beat;
   logic          final_beat;
   logic          core_store;
   logic          mmio_hit;
   logic [15:0]   mmio_out;
   logic          mmio_stb;

   logic [1:0]    w_en;
   logic [AW-1:0] w_addr;
   logic [15:0]   w_data;
   logic [15:0]   rd_i;
   logic [15:0]   rd_d;

   // ld_start wins over a simultaneous beat; nothing is accepted during rst
   assign ld_ready   = (state == LOAD) && !bus.ld_start && !rst;
   assign beat       = ld_ready && bus.ld_valid;
   // the load ends on ld_last or when the last RAM word has been filled
   assign final_beat = beat && (bus.ld_last || (ld_count == LAST_IDX));
   assign core_store = (state == RUN) && !cpu_rst && !rst && (bus.d_we != WE_NONE);

   always_comb begin
      next_state = state;
      if (bus.ld_start) begin
         next_state = LOAD;
      end else if (final_beat) begin
         next_state = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cpu_rst  <= 1'b1;
         ld_count <= '0;
         ld_ovf   <= 1'b0;
      end else begin
         state   <= next_state;
         // registered from next_state so the core leaves reset the cycle
         // after the final beat and sees the complete program
         cpu_rst <= (next_state != RUN);
         if (bus.ld_start) begin
            ld_count <= '0;
            ld_ovf   <= 1'b0;
         end else if (beat) begin
            ld_count <= ld_count + (AW+1)'(1);
            if (final_beat && !bus.ld_last) ld_ovf <= 1'b1;
         end
      end
   end

   // RAM write port: loader beats (full word) or core stores (byte lanes).
   // The two never coincide because beats only occur in LOAD.
   always_comb begin
      w_en   = WE_NONE;
      w_addr = bus.d_addr[AW:1];
      w_data = bus.d_wdata;
      if (beat) begin
         w_en   = WE_WORD;
         w_addr = ld_count[AW-1:0];
         w_data = bus.ld_data;
      end else if (core_store && !mmio_hit) begin
         w_en = bus.d_we;
      end
   end

   risc16_bram #(.AW(AW)) u_bram (
      .clk     (clk),
      .ra_addr (bus.i_addr[AW:1]),
      .ra_data (rd_i),
      .rb_addr (bus.d_addr[AW:1]),
      .rb_data (rd_d),
      .w_en    (w_en),
      .w_addr  (w_addr),
      .w_data  (w_data)
   );

   assign bus.i_rdata = bus.i_oe ? rd_i : 16'h0000;

`ifdef RISC16_MMIO_EN
   assign mmio_hit = (bus.d_addr == MMIO_ADDR);

   always_ff @(posedge clk) begin
      if (rst) begin
         mmio_out <= 16'h0000;
         mmio_stb <= 1'b0;
      end else begin
         mmio_stb <= core_store && mmio_hit;
         if (core_store && mmio_hit) begin
            mmio_out <= merge_lanes(mmio_out, bus.d_wdata, bus.d_we);
         end
      end
   end

   assign bus.d_rdata = !bus.d_oe ? 16'h0000 : (mmio_hit ? mmio_out : rd_d);
`else
   logic unused_mmio;

   assign mmio_hit    = 1'b0;
   assign mmio_out    = 16'h0000;
   assign mmio_stb    = 1'b0;
   assign unused_mmio = &{1'b0, MMIO_ADDR};
   assign bus.d_rdata = bus.d_oe ? rd_d : 16'h0000;
`endif

   // upper address bits alias and bit 0 is carried by d_we
   logic unused_addr;
   assign unused_addr = &{1'b0, bus.i_addr[15:AW+1], bus.i_addr[0],
                          bus.d_addr[15:AW+1], bus.d_addr[0]};

   assign bus.ld_ready = ld_ready;
   assign bus.cpu_rst  = cpu_rst;
   assign bus.ld_count = ld_count;
   assign bus.ld_ovf   = ld_ovf;
   assign bus.mmio_out = mmio_out;
   assign bus.mmio_stb = mmio_stb;

endmodule
